// File: rtl/multi_channel_synchronizer.sv
// ---------------------------------------------------------------------------
// multi_channel_synchronizer
//
// Brings NCH asynchronous pad inputs (SPI SCLK, CS_n, MOSI, spare GPIO) into
// the clk domain. Each channel has its own synchronizer chain, an optional
// glitch filter, an edge detector and a sticky edge-event flag. Channels
// share nothing but the clock and reset.
//
// Ports
//   clk         : device clock
//   reset       : asynchronous, active-low reset
//   in_         : [NCH] raw asynchronous inputs
//   filter_en   : [NCH] per-channel glitch-filter enable (sampled each cycle)
//   evt_clr     : [NCH] per-channel clear of evt_pending
//   out         : [NCH] filtered, synchronized level
//   posedge_    : [NCH] one-cycle pulse on an accepted 0->1 of out
//   negedge_    : [NCH] one-cycle pulse on an accepted 1->0 of out
//   evt_pending : [NCH] sticky flag, set by any accepted edge
// ---------------------------------------------------------------------------
module multi_channel_synchronizer #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned STAGES      = 2,
  parameter int unsigned FILTER_LEN  = 3,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] in_,
  input  logic [NCH-1:0] filter_en,
  input  logic [NCH-1:0] evt_clr,
  output logic [NCH-1:0] out,
  output logic [NCH-1:0] posedge_,
  output logic [NCH-1:0] negedge_,
  output logic [NCH-1:0] evt_pending
);

  localparam int unsigned     CNT_W    = $clog2(FILTER_LEN + 1);
  // Count value at which the next differing sample completes FILTER_LEN.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [STAGES-1:0] sync_q;
    logic              filt_q;
    logic              filt_d;
    logic              filt_dly_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              pend_q;
    logic              pend_d;
    logic              sync_x;
    logic              rise;
    logic              fall;

    // Only sync_q[0] can go metastable; it feeds nothing but sync_q[1].
    assign sync_x = sync_q[STAGES-1];

    // Glitch filter: a differing level must be seen on FILTER_LEN
    // consecutive cycles; any return to the current level restarts the
    // count. With filtering off (or FILTER_LEN==1) the level passes through.
    always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (!filter_en[i]) begin
        filt_d = sync_x;
      end else if (sync_x != filt_q) begin
        if (cnt_q == CNT_LAST) begin
          filt_d = sync_x;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    // Edge detect against the previous filtered level.
    assign rise = filt_q & ~filt_dly_q;
    assign fall = ~filt_q & filt_dly_q;

    // Set has priority over clear so an edge coincident with a clear is kept.
    assign pend_d = (pend_q & ~evt_clr[i]) | rise | fall;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q     <= {STAGES{RESET_VALUE}};
        filt_q     <= RESET_VALUE;
        filt_dly_q <= RESET_VALUE;
        cnt_q      <= '0;
        pend_q     <= 1'b0;
      end else begin
        sync_q     <= {sync_q[STAGES-2:0], in_[i]};
        filt_q     <= filt_d;
        filt_dly_q <= filt_q;
        cnt_q      <= cnt_d;
        pend_q     <= pend_d;
      end
    end

    assign out[i]         = filt_q;
    assign posedge_[i]    = rise;
    assign negedge_[i]    = fall;
    assign evt_pending[i] = pend_q;
  end

endmodule

// File: tb/tb_multi_channel_synchronizer.sv
// ---------------------------------------------------------------------------
// tb_multi_channel_synchronizer
//
// Three instances are exercised side by side and treated as 7 lanes:
//   lanes 0-3 : NCH=4, STAGES=2, FILTER_LEN=3, RESET_VALUE=0
//   lanes 4-5 : NCH=2, STAGES=3, FILTER_LEN=4, RESET_VALUE=1
//   lane  6   : NCH=1, STAGES=2, FILTER_LEN=1, RESET_VALUE=1
// A lane model (input history + run-length filter rule) predicts every
// output each cycle; directed tables and sequences add explicit checks.
// ---------------------------------------------------------------------------
module tb_multi_channel_synchronizer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] raw;
  logic [6:0] fen;
  logic [6:0] clr;
  wire  [6:0] out_all;
  wire  [6:0] pos_all;
  wire  [6:0] neg_all;
  wire  [6:0] pend_all;

  always #5 clk = ~clk;

  multi_channel_synchronizer #(.NCH(4), .STAGES(2), .FILTER_LEN(3), .RESET_VALUE(1'b0)) dut (
    .clk(clk), .reset(rst_n), .in_(raw[3:0]), .filter_en(fen[3:0]), .evt_clr(clr[3:0]),
    .out(out_all[3:0]), .posedge_(pos_all[3:0]), .negedge_(neg_all[3:0]),
    .evt_pending(pend_all[3:0]));

  multi_channel_synchronizer #(.NCH(2), .STAGES(3), .FILTER_LEN(4), .RESET_VALUE(1'b1)) dut2 (
    .clk(clk), .reset(rst_n), .in_(raw[5:4]), .filter_en(fen[5:4]), .evt_clr(clr[5:4]),
    .out(out_all[5:4]), .posedge_(pos_all[5:4]), .negedge_(neg_all[5:4]),
    .evt_pending(pend_all[5:4]));

  multi_channel_synchronizer #(.NCH(1), .STAGES(2), .FILTER_LEN(1), .RESET_VALUE(1'b1)) dut3 (
    .clk(clk), .reset(rst_n), .in_(raw[6:6]), .filter_en(fen[6:6]), .evt_clr(clr[6:6]),
    .out(out_all[6:6]), .posedge_(pos_all[6:6]), .negedge_(neg_all[6:6]),
    .evt_pending(pend_all[6:6]));

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  bit         m_f    [7];
  bit         m_fp   [7];
  bit         m_pend [7];
  int         m_run  [7];
  bit [6:0]   log_a  [4096];
  int         ncyc;

  function automatic int lane_stages(int l);
    if (l < 4) return 2;
    else if (l < 6) return 3;
    else return 2;
  endfunction

  function automatic int lane_flen(int l);
    if (l < 4) return 3;
    else if (l < 6) return 4;
    else return 1;
  endfunction

  function automatic bit lane_rv(int l);
    return (l >= 4);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 7; l++) begin
      m_f[l]    = lane_rv(l);
      m_fp[l]   = lane_rv(l);
      m_pend[l] = 1'b0;
      m_run[l]  = 0;
    end
    ncyc = 0;
  endtask

  // One clock edge: inputs are those present just before the edge.
  task automatic model_step();
    bit x;
    bit pulse;
    for (int l = 0; l < 7; l++) begin
      // The filter sees the raw input as it was STAGES edges ago.
      x = (ncyc >= lane_stages(l)) ? log_a[ncyc - lane_stages(l)][l] : lane_rv(l);
      pulse     = m_f[l] ^ m_fp[l];
      m_pend[l] = (m_pend[l] & ~clr[l]) | pulse;
      m_fp[l]   = m_f[l];
      if (!fen[l]) begin
        m_f[l] = x; m_run[l] = 0;
      end else if (x == m_f[l]) begin
        m_run[l] = 0;
      end else begin
        m_run[l]++;
        if (m_run[l] >= lane_flen(l)) begin
          m_f[l] = x; m_run[l] = 0;
        end
      end
    end
    if (ncyc < 4096) log_a[ncyc] = raw;
    ncyc++;
  endtask

  task automatic model_check();
    logic [6:0] e_out, e_pos, e_neg, e_pend;
    for (int l = 0; l < 7; l++) begin
      e_out[l]  = m_f[l];
      e_pos[l]  = m_f[l] & ~m_fp[l];
      e_neg[l]  = ~m_f[l] & m_fp[l];
      e_pend[l] = m_pend[l];
    end
    chk("model_out",  out_all,  e_out);
    chk("model_pos",  pos_all,  e_pos);
    chk("model_neg",  neg_all,  e_neg);
    chk("model_pend", pend_all, e_pend);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    model_check();
  endtask

  task automatic latency(int lane, bit v, int exp_lat, string name);
    int n;
    n = 0;
    raw[lane] = v;
    while (n < 20) begin
      cycle();
      n++;
      if (out_all[lane] == v) break;
    end
    chk(name, n, exp_lat);
  endtask

  task automatic wait_bit(input logic [6:0] vec_sel, int lane, string name);
    int n;
    n = 0;
    while (n < 12) begin
      cycle();
      n++;
      if ((vec_sel == 7'd0 ? pos_all[lane] : neg_all[lane]) == 1'b1) break;
    end
    chk(name, (n < 12), 1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0] in_v;
    logic [3:0] clr_v;
    logic [3:0] out_v;
    logic [3:0] pos_v;
    logic [3:0] neg_v;
    logic [3:0] pend_v;
  } vec_t;

  vec_t tbl [18];

  initial begin
    int idx;
    // ch0 unfiltered rise/fall, ch1 filtered rise then a 2-cycle glitch.
    tbl[0]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b0011, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
    tbl[4]  = '{4'b0011, 4'b0000, 4'b0011, 4'b0010, 4'b0000, 4'b0001};
    tbl[5]  = '{4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0011};
    tbl[6]  = '{4'b0010, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0011};
    tbl[7]  = '{4'b0010, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0011};
    tbl[8]  = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0011};
    tbl[9]  = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0011};
    tbl[10] = '{4'b0010, 4'b0011, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    tbl[11] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    tbl[12] = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    tbl[14] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    tbl[15] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    tbl[16] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    tbl[17] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};

    raw   = 7'b1110000;
    fen   = 7'b0000000;
    clr   = 7'b0000000;
    rst_n = 1'b1;
    model_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("reset_out",  out_all,  7'b1110000);
    chk("reset_pos",  pos_all,  7'b0000000);
    chk("reset_neg",  neg_all,  7'b0000000);
    chk("reset_pend", pend_all, 7'b0000000);
    repeat (2) cycle();
    @(negedge clk) rst_n = 1'b1;
    fen = 7'b0000010;
    repeat (4) cycle();
    chk("idle_out", out_all, 7'b1110000);

    for (int r = 0; r < 18; r++) begin
      raw[3:0] = tbl[r].in_v;
      clr[3:0] = tbl[r].clr_v;
      cycle();
      chk($sformatf("tbl%0d_out",  r), out_all[3:0],  tbl[r].out_v);
      chk($sformatf("tbl%0d_pos",  r), pos_all[3:0],  tbl[r].pos_v);
      chk($sformatf("tbl%0d_neg",  r), neg_all[3:0],  tbl[r].neg_v);
      chk($sformatf("tbl%0d_pend", r), pend_all[3:0], tbl[r].pend_v);
    end
    clr = '0;

    // Alternating every cycle on a filtered channel never gets through.
    for (int k = 0; k < 8; k++) begin
      raw[1] = k[0];
      cycle();
      chk("alt_out1", out_all[1], 1'b1);
      chk("alt_pos1", pos_all[1] | neg_all[1], 1'b0);
    end
    raw[1] = 1'b1;
    repeat (6) cycle();

    // Sticky flag on ch2 (unfiltered).
    raw[2] = 1'b1;
    wait_bit(7'd0, 2, "sticky_rise_seen");
    repeat (10) cycle();
    chk("sticky_hold", pend_all[2], 1'b1);
    clr[2] = 1'b1;
    cycle();
    clr[2] = 1'b0;
    chk("sticky_clr", pend_all[2], 1'b0);
    clr[2] = 1'b1;
    cycle();
    clr[2] = 1'b0;
    chk("clr_idle", pend_all[2], 1'b0);
    raw[2] = 1'b0;
    wait_bit(7'd1, 2, "sticky_fall_seen");
    clr[2] = 1'b1;
    cycle();
    clr[2] = 1'b0;
    chk("set_wins", pend_all[2], 1'b1);

    // Dropping filter_en mid-count lets the level through on the next edge.
    raw[1] = 1'b0;
    repeat (3) cycle();
    chk("midcount_held", out_all[1], 1'b1);
    fen[1] = 1'b0;
    cycle();
    chk("midcount_drop", out_all[1], 1'b0);
    fen[1] = 1'b1;

    // Latency for each parameterisation.
    fen = 7'b1110010;
    raw = 7'b1110000;
    repeat (10) cycle();
    latency(0, 1'b1, 3, "lat_s2_off");
    latency(1, 1'b1, 5, "lat_s2_f3");
    latency(4, 1'b0, 7, "lat_s3_f4");
    latency(6, 1'b0, 3, "lat_s2_f1");

    // Async reset with outputs high; no edge reported across it.
    raw = 7'b0001111;
    repeat (10) cycle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_out",  out_all,  7'b1110000);
    chk("areset_pos",  pos_all,  7'b0000000);
    chk("areset_neg",  neg_all,  7'b0000000);
    chk("areset_pend", pend_all, 7'b0000000);
    model_reset();
    raw = 7'b1110000;
    repeat (3) cycle();
    @(negedge clk) rst_n = 1'b1;
    repeat (6) cycle();
    chk("release_pend", pend_all, 7'b0000000);

    // Randomized traffic, mixed filter enables.
    fen[3:0] = 4'b0101;
    for (int n = 0; n < 800; n++) begin
      for (int b = 0; b < 7; b++)
        if ($urandom_range(3) == 0) raw[b] = ~raw[b];
      if ($urandom_range(19) == 0) begin
        idx = $urandom_range(6);
        fen[idx] = ~fen[idx];
      end
      clr = 7'($urandom) & 7'($urandom) & 7'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
